// File: rtl/masked_tag_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : masked_tag_ram_pkg
//  Description : Shared defaults, FSM state encoding and address-width helper
//                for the masked tag RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package masked_tag_ram_pkg;

    localparam int DEFAULT_DEPTH     = 64;
    localparam int DEFAULT_WIDTH     = 184;
    localparam int DEFAULT_MASK_GRAN = 23;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        READY = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic int addr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/masked_tag_ram_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : masked_tag_ram_sweep
//  Description : INIT/READY/FLUSH controller that zeroes one row per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module masked_tag_ram_sweep
    import masked_tag_ram_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush_req,
    output logic          ready,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr
);

    localparam logic [AW-1:0] c_last_row = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        sweep_we    = 1'b0;
        ready       = 1'b0;
        case (r_state)
            INIT, FLUSH: begin
                sweep_we = 1'b1;
                if (r_cnt == c_last_row) begin
                    w_state_nxt = READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + AW'(1);
                end
            end
            READY: begin
                ready = 1'b1;
                // A flush never blocks the read/write accepted in this cycle.
                if (flush_req) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign sweep_addr = r_cnt;

endmodule
`default_nettype wire

// File: rtl/masked_tag_ram.sv
`default_nettype none
// ============================================================================
//  Module      : masked_tag_ram
//  Description : Lane-masked 1R1W tag RAM with one-cycle reads, write-to-read
//                bypass and a zeroing sweep on reset and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module masked_tag_ram
    import masked_tag_ram_pkg::*;
#(
    parameter  int DEPTH     = DEFAULT_DEPTH,
    parameter  int WIDTH     = DEFAULT_WIDTH,
    parameter  int MASK_GRAN = DEFAULT_MASK_GRAN,
    localparam int LANES     = WIDTH / MASK_GRAN,
    localparam int AW        = addr_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             R0_en,
    input  logic [AW-1:0]    R0_addr,
    output logic [WIDTH-1:0] R0_data,
    output logic             R0_valid,
    input  logic             W0_en,
    input  logic [AW-1:0]    W0_addr,
    input  logic [WIDTH-1:0] W0_data,
    input  logic [LANES-1:0] W0_mask,
    input  logic             flush_req,
    output logic             ready
);

    localparam logic [AW:0] c_depth_ext = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_sweep_we;
    logic [AW-1:0]    w_sweep_addr;
    logic             w_wr_inrange;
    logic             w_rd_inrange;
    logic             w_user_we;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_addr;
    logic [LANES-1:0] w_mem_lanes;
    logic [WIDTH-1:0] w_mem_data;
    logic [AW-1:0]    w_rd_idx;
    logic             w_bypass;
    logic [WIDTH-1:0] w_rd_row;

    masked_tag_ram_sweep #(
        .DEPTH (DEPTH)
    ) u_sweep (
        .clock      (clock),
        .reset      (reset),
        .flush_req  (flush_req),
        .ready      (ready),
        .sweep_we   (w_sweep_we),
        .sweep_addr (w_sweep_addr)
    );

    assign w_wr_inrange = ({1'b0, W0_addr} < c_depth_ext);
    assign w_rd_inrange = ({1'b0, R0_addr} < c_depth_ext);
    assign w_user_we    = W0_en & ready & w_wr_inrange;

    // The sweep only runs while ready=0, so it never competes with a user write.
    assign w_mem_we    = w_sweep_we | w_user_we;
    assign w_mem_addr  = w_sweep_we ? w_sweep_addr : W0_addr;
    assign w_mem_lanes = w_sweep_we ? '1 : W0_mask;
    assign w_mem_data  = w_sweep_we ? '0 : W0_data;

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_mem_lanes[l]) begin
                    r_mem[w_mem_addr][l*MASK_GRAN +: MASK_GRAN] <= w_mem_data[l*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    assign w_rd_idx = w_rd_inrange ? R0_addr : '0;
    assign w_bypass = w_user_we & (W0_addr == R0_addr);

    always_comb begin
        w_rd_row = r_mem[w_rd_idx];
        if (w_bypass) begin
            for (int l = 0; l < LANES; l++) begin
                if (W0_mask[l]) begin
                    w_rd_row[l*MASK_GRAN +: MASK_GRAN] = W0_data[l*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            R0_data  <= '0;
            R0_valid <= 1'b0;
        end else if (R0_en && ready) begin
            R0_valid <= 1'b1;
            R0_data  <= w_rd_inrange ? w_rd_row : '0;
        end else begin
            R0_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_masked_tag_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_masked_tag_ram
//  Description : Directed self-checking bench for masked_tag_ram (DEPTH 64/48).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_masked_tag_ram;

    localparam logic [183:0] c_zero = '0;
    localparam logic [183:0] c_ones = '1;
    localparam logic [183:0] c_e5   = {{161{1'b1}}, {23{1'b0}}};
    localparam logic [183:0] c_e9   = {{23{1'b0}}, {161{1'b1}}};
    localparam logic [183:0] c_pat  = {8{23'h2AAAAA}};

    logic         clock;
    logic         reset;
    logic         flush_req;

    logic         r0_en;
    logic [5:0]   r0_addr;
    logic [183:0] r0_data;
    logic         r0_valid;
    logic         w0_en;
    logic [5:0]   w0_addr;
    logic [183:0] w0_data;
    logic [7:0]   w0_mask;
    logic         ready;

    logic         b_r0_en;
    logic [5:0]   b_r0_addr;
    logic [183:0] b_r0_data;
    logic         b_r0_valid;
    logic         b_w0_en;
    logic [5:0]   b_w0_addr;
    logic [183:0] b_w0_data;
    logic [7:0]   b_w0_mask;
    logic         b_flush_req;
    logic         b_ready;

    int n_pass  = 0;
    int n_total = 0;

    masked_tag_ram dut (
        .clock     (clock),
        .reset     (reset),
        .R0_en     (r0_en),
        .R0_addr   (r0_addr),
        .R0_data   (r0_data),
        .R0_valid  (r0_valid),
        .W0_en     (w0_en),
        .W0_addr   (w0_addr),
        .W0_data   (w0_data),
        .W0_mask   (w0_mask),
        .flush_req (flush_req),
        .ready     (ready)
    );

    masked_tag_ram #(
        .DEPTH (48)
    ) dut48 (
        .clock     (clock),
        .reset     (reset),
        .R0_en     (b_r0_en),
        .R0_addr   (b_r0_addr),
        .R0_data   (b_r0_data),
        .R0_valid  (b_r0_valid),
        .W0_en     (b_w0_en),
        .W0_addr   (b_w0_addr),
        .W0_data   (b_w0_data),
        .W0_mask   (b_w0_mask),
        .flush_req (b_flush_req),
        .ready     (b_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [183:0] obs, input logic [183:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1;  flush_req = 1'b0;
        r0_en = 1'b0;  r0_addr = '0;  w0_en = 1'b0;  w0_addr = '0;  w0_data = '0;  w0_mask = '0;
        b_r0_en = 1'b0; b_r0_addr = '0; b_w0_en = 1'b0; b_w0_addr = '0; b_w0_data = '0; b_w0_mask = '0;
        b_flush_req = 1'b0;
        tick();
        tick();
        check("rst_ready", ready, 1'b0);
        check("rst_valid", r0_valid, 1'b0);
        check("rst_data", r0_data, c_zero);

        // Reset release: DEPTH=48 ready after 48 edges, DEPTH=64 after 64.
        reset = 1'b0;
        repeat (47) tick();
        check("init48_not_ready_47", b_ready, 1'b0);
        tick();
        check("init48_ready_48", b_ready, 1'b1);
        repeat (15) tick();
        check("init_not_ready_63", ready, 1'b0);
        tick();
        check("init_ready_64", ready, 1'b1);

        r0_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            r0_addr = i[5:0];
            tick();
            check("init_row_valid", r0_valid, 1'b1);
            check("init_row_zero", r0_data, c_zero);
        end
        r0_en = 1'b0;

        // Masked overwrite of lane 0 only.
        w0_en = 1'b1; w0_addr = 6'd5; w0_data = c_ones; w0_mask = 8'hFF;
        tick();
        w0_data = c_zero; w0_mask = 8'h01;
        tick();
        w0_en = 1'b0; r0_en = 1'b1; r0_addr = 6'd5;
        tick();
        check("masked_row5_valid", r0_valid, 1'b1);
        check("masked_row5_data", r0_data, c_e5);

        // Same-row read+write bypass on lane 7.
        r0_en = 1'b0; w0_en = 1'b1; w0_addr = 6'd9; w0_data = c_ones; w0_mask = 8'hFF;
        tick();
        w0_data = c_zero; w0_mask = 8'h80; r0_en = 1'b1; r0_addr = 6'd9;
        tick();
        check("bypass_row9", r0_data, c_e9);
        w0_en = 1'b0;
        tick();
        check("stored_row9", r0_data, c_e9);

        // Read and write to different rows in one cycle.
        w0_en = 1'b1; w0_addr = 6'd10; w0_data = c_pat; w0_mask = 8'hFF; r0_addr = 6'd5;
        tick();
        check("diff_rows_read5", r0_data, c_e5);
        w0_en = 1'b0; r0_addr = 6'd10;
        tick();
        check("diff_rows_read10", r0_data, c_pat);

        r0_en = 1'b0;
        tick();
        check("idle_valid_low", r0_valid, 1'b0);
        check("idle_data_hold", r0_data, c_pat);

        w0_en = 1'b1; w0_addr = 6'd10; w0_data = c_zero; w0_mask = 8'h00;
        tick();
        w0_en = 1'b0; r0_en = 1'b1; r0_addr = 6'd10;
        tick();
        check("zero_mask_no_write", r0_data, c_pat);

        // Flush with a same-cycle write and read, then a sweep of 64 cycles.
        r0_addr = 6'd5; w0_en = 1'b1; w0_addr = 6'd3; w0_data = c_ones; w0_mask = 8'hFF; flush_req = 1'b1;
        tick();
        check("flush_cycle_read_valid", r0_valid, 1'b1);
        check("flush_cycle_read_data", r0_data, c_e5);
        check("flush_ready_low", ready, 1'b0);
        flush_req = 1'b0; w0_en = 1'b0; r0_addr = 6'd3;
        tick();
        check("sweep_read_no_valid", r0_valid, 1'b0);
        check("sweep_read_data_hold", r0_data, c_e5);
        r0_en = 1'b0; flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (61) tick();
        check("flush_not_ready_63", ready, 1'b0);
        tick();
        check("flush_ready_64", ready, 1'b1);
        r0_en = 1'b1; r0_addr = 6'd3;
        tick();
        check("flushed_row3_valid", r0_valid, 1'b1);
        check("flushed_row3_zero", r0_data, c_zero);
        r0_addr = 6'd5;
        tick();
        check("flushed_row5_zero", r0_data, c_zero);
        r0_en = 1'b0;

        // Out-of-range address on the DEPTH=48 instance.
        b_w0_en = 1'b1; b_w0_addr = 6'd2; b_w0_data = c_pat; b_w0_mask = 8'hFF;
        tick();
        b_w0_addr = 6'd50; b_w0_data = c_ones; b_r0_en = 1'b1; b_r0_addr = 6'd50;
        tick();
        check("oob_same_cycle_valid", b_r0_valid, 1'b1);
        check("oob_same_cycle_zero", b_r0_data, c_zero);
        b_w0_en = 1'b0; b_r0_addr = 6'd2;
        tick();
        check("oob_alias_row2_unchanged", b_r0_data, c_pat);
        b_r0_addr = 6'd50;
        tick();
        check("oob_read_valid", b_r0_valid, 1'b1);
        check("oob_read_zero", b_r0_data, c_zero);
        b_r0_en = 1'b0;

        // Reset at INIT sweep cycle 20 restarts the full sweep.
        w0_en = 1'b1; w0_addr = 6'd1; w0_data = c_pat; w0_mask = 8'hFF;
        tick();
        w0_en = 1'b0; r0_en = 1'b1; r0_addr = 6'd1;
        tick();
        check("pre_reset_row1", r0_data, c_pat);
        r0_en = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (20) tick();
        reset = 1'b1; r0_en = 1'b1; r0_addr = 6'd1;
        tick();
        check("midsweep_rst_ready", ready, 1'b0);
        check("midsweep_rst_valid", r0_valid, 1'b0);
        check("midsweep_rst_data", r0_data, c_zero);
        reset = 1'b0;
        repeat (63) tick();
        check("restart_not_ready_63", ready, 1'b0);
        check("restart_no_valid", r0_valid, 1'b0);
        tick();
        check("restart_ready_64", ready, 1'b1);
        tick();
        check("restart_row1_zero", r0_data, c_zero);
        check("restart_row1_valid", r0_valid, 1'b1);
        r0_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/masked_tag_ram.md
MASKED_TAG_RAM -- requirements
Module: masked_tag_ram

Interface
REQ-001 Parameter DEPTH, default 64, number of rows; SHALL be at least 2 and need not be a power of two.
REQ-002 Parameter WIDTH, default 184, row width in bits.
REQ-003 Parameter MASK_GRAN, default 23, bits per mask lane; WIDTH SHALL be a multiple of MASK_GRAN, and LANES = WIDTH/MASK_GRAN.
REQ-004 Derived constant AW = max(1, ceil(log2(DEPTH))) SHALL size all address ports.
REQ-005 Ports SHALL be:
- clock  in  1  sole clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- R0_en  in  1  read request.
- R0_addr  in  AW  read row.
- R0_data  out  WIDTH  read data.
- R0_valid  out  1  R0_data holds the result of an accepted read.
- W0_en  in  1  write request.
- W0_addr  in  AW  write row.
- W0_data  in  WIDTH  write data.
- W0_mask  in  LANES  lane i enables bits [i*MASK_GRAN +: MASK_GRAN].
- flush_req  in  1  pulse; clears all rows to zero.
- ready  out  1  array accepts reads and writes.

Function
REQ-006 The FSM SHALL have states INIT, READY and FLUSH; reset SHALL enter INIT with sweep counter 0.
REQ-007 In INIT and FLUSH, one row per cycle SHALL be written with all zeros at the counter value, in ascending order; after row DEPTH-1 the FSM SHALL enter READY on the next edge, so a sweep lasts exactly DEPTH cycles.
REQ-008 ready SHALL be 1 only in READY; reads and writes presented while ready=0 SHALL be ignored and produce no R0_valid.
REQ-009 In READY, flush_req=1 SHALL enter FLUSH with counter 0 on the next edge; any read or write presented in that same cycle SHALL still complete normally.
REQ-010 flush_req SHALL be ignored in INIT and FLUSH, with no restart or queuing.
REQ-011 A write (W0_en=1, ready=1) SHALL update only the lanes whose mask bit is 1 at the edge; other lanes SHALL keep their value; an all-zero mask SHALL write nothing.
REQ-012 Read latency SHALL be one cycle: a read accepted at edge N SHALL drive R0_data and R0_valid=1 after edge N.
REQ-013 When no read is accepted, R0_valid SHALL be 0 and R0_data SHALL hold its last value.
REQ-014 Same-cycle read and write to the same in-range row SHALL bypass per lane: enabled lanes return W0_data, other lanes return the stored data.
REQ-015 An address >= DEPTH SHALL be ignored on writes; a read of it SHALL return all zeros with R0_valid=1.
REQ-016 Reads and writes to different rows in the same cycle SHALL both complete without interaction.

Reset
REQ-017 On reset: R0_data=0, R0_valid=0, ready=0, state INIT, counter 0.
REQ-018 Reset asserted mid-sweep or mid-read SHALL abandon the operation and restart INIT from row 0 on the next edge.
REQ-019 Array contents SHALL never be read as X; the INIT sweep is the only mechanism that clears them.

Structure
REQ-020 Package masked_tag_ram_pkg SHALL hold the state enum (INIT/READY/FLUSH) and the default values of DEPTH, WIDTH and MASK_GRAN.
REQ-021 The sweep counter and FSM SHALL be one sub-module, masked_tag_ram_sweep (outputs: ready, sweep_we, sweep_addr).
REQ-022 The storage SHALL be a plain reg array, inferable as a single-port-write/single-port-read RAM.

Verification (DEPTH=64, WIDTH=184, MASK_GRAN=23)
REQ-023 Release reset, then idle -> ready rises exactly 64 cycles after reset deasserts; a read of each row returns 0.
REQ-024 Write row 5 with all ones and mask 8'hFF, then write row 5 with all zeros and mask 8'h01 -> a read returns bits [22:0]=0 and [183:23]=all ones.
REQ-025 Same cycle: write row 9 with data 184'h0 and mask 8'h80, and read row 9 holding all ones -> the next cycle R0_data[183:161]=0 and the rest is all ones.
REQ-026 Pulse flush_req with a write to row 3 in the same cycle -> ready drops for 64 cycles, a read issued during the sweep gives no R0_valid, and row 3 reads 0 after the sweep.
REQ-027 DEPTH=48: write then read address 50 -> R0_valid=1 and R0_data=0; row 50 mod 48 is unchanged.
REQ-028 Assert reset at sweep cycle 20 -> ready rises exactly 64 cycles after reset deasserts.
